round_ctrl: RTL and testbench
=============================

Name: round_ctrl

Overview:
Upstream game-round controller that drives the LED/score stage. It turns a debounced "go" button pulse into a timed round: it holds start high for ROUND_SECS seconds, pulses change at a fixed cadence, and supplies randNum in the range 0..2 from a free-running LFSR. It also exports the remaining seconds for the display and a one-cycle done pulse when the round ends.

Parameters:
CYCLES_PER_SEC, 50_000_000, clk cycles per game second
ROUND_SECS, 30, round length in seconds (1..63)
CHANGE_CYCLES, 25_000_000, clk cycles between change pulses (>=2)
LFSR_SEED, 8'hA5, nonzero reset value of the LFSR

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
go  input  1  one-cycle debounced start-button pulse
start  output  1  high for the whole round
change  output  1  one-cycle pulse; randNum is valid in the same cycle
randNum  output  2  LED select, always 0, 1 or 2
timeLeft  output  6  seconds remaining (display)
done  output  1  one-cycle pulse at round end

Behaviour:
- All logic is on posedge clk. All outputs are registered.
- rst==0 at an edge: state=IDLE, start=0, change=0, done=0, randNum=0, timeLeft=0, sec_cnt=0, chg_cnt=0, lfsr=LFSR_SEED. Reset takes priority over everything, including mid-round.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every non-reset cycle in every state. Period is 255.
  - If the LFSR is ever all-zero, reload it with LFSR_SEED.
- randNum mapping, from the current lfsr: lfsr[1:0] when that value != 3; otherwise {1'b0, lfsr[2]}. The result is never 3.
- States: IDLE, RUN, DONE.
- IDLE/DONE with go==1 at an edge -> RUN. On that same edge:
  - start<=1, change<=1, randNum<=mapped value
  - timeLeft<=ROUND_SECS, sec_cnt<=0, chg_cnt<=0, done<=0
  - The first LED therefore lights in the first RUN cycle.
- RUN, each edge:
  - chg_cnt increments. When chg_cnt==CHANGE_CYCLES-1: chg_cnt<=0, change<=1, randNum<=mapped value. Otherwise change<=0 and randNum holds.
  - Change pulses occur at RUN cycles 0, C, 2C, ... (C = CHANGE_CYCLES).
  - sec_cnt increments. When sec_cnt==CYCLES_PER_SEC-1: sec_cnt<=0 and timeLeft decrements.
  - If timeLeft==1 at that wrap -> DONE: timeLeft<=0, start<=0, done<=1, change<=0. End-of-round overrides a coincident change pulse.
  - start is high for exactly ROUND_SECS*CYCLES_PER_SEC cycles.
- go while in RUN is ignored; there is no restart or extension.
- DONE: done is high for one cycle only, then 0. start=0, change=0, timeLeft=0, randNum holds. Remains in DONE until go.
- In IDLE and DONE, change is never asserted.
- Downstream contract: start falling resets nothing here. Downstream clears its score on the next start rise.

Test Plan:
All scenarios use CYCLES_PER_SEC=10, ROUND_SECS=3, CHANGE_CYCLES=4.
1. Assert rst low for 2 cycles, release -> all outputs 0, state IDLE. Pulse go -> at the next edge start=1, change=1, timeLeft=3, randNum in {0,1,2}.
2. Run the round -> change is high exactly at RUN cycles 0,4,8,...,28 (8 pulses), each 1 cycle wide. timeLeft reads 3,2,1 and changes every 10 cycles.
3. Count through the round -> start is high for exactly 30 cycles. In the cycle after RUN cycle 29: start=0, timeLeft=0, done=1 for one cycle. No change pulse at or after the end.
4. Pulse go at RUN cycle 12 -> no effect: timeLeft and the change cadence are unchanged. Pulse go in DONE -> new round with start=1, timeLeft=3, change=1.
5. Drive rst low for 1 cycle at RUN cycle 15 -> next cycle start=0, timeLeft=0, change=0, lfsr=8'hA5. Pulse go after an exactly known delay -> randNum sequence matches a golden model seeded with 8'hA5.
6. Run 2000 consecutive rounds (go pulsed whenever done) -> randNum is never 3 and all of 0, 1 and 2 occur. Independently, the LFSR returns to 8'hA5 after exactly 255 shifts.

Source files
------------

// File: rtl/round_ctrl_if.sv
// Handshake bundle between the round controller and the LED/score stage.
// master = round controller, slave = the block that pulses go and consumes the round.
interface round_ctrl_if;
    logic       go;
    logic       start;
    logic       change;
    logic [1:0] randNum;
    logic [5:0] timeLeft;
    logic       done;

    modport master (
        input  go,
        output start,
        output change,
        output randNum,
        output timeLeft,
        output done
    );

    modport slave (
        output go,
        input  start,
        input  change,
        input  randNum,
        input  timeLeft,
        input  done
    );
endinterface

// File: rtl/round_ctrl.sv
// Game-round controller: turns a go pulse into a timed round with periodic
// change pulses carrying a pseudo-random LED select (0..2).
module round_ctrl #(
    parameter int unsigned CYCLES_PER_SEC = 50_000_000,
    parameter int unsigned ROUND_SECS     = 30,
    parameter int unsigned CHANGE_CYCLES  = 25_000_000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    round_ctrl_if.master bus
);

    localparam int unsigned SEC_W  = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int unsigned CHG_W  = (CHANGE_CYCLES > 1) ? $clog2(CHANGE_CYCLES) : 1;
    localparam int unsigned TIME_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic                start_q,     start_d;
    logic                change_q,    change_d;
    logic                done_q,      done_d;
    logic [1:0]          rand_q,      rand_d;
    logic [TIME_W-1:0]   time_left_q, time_left_d;
    logic [SEC_W-1:0]    sec_cnt_q,   sec_cnt_d;
    logic [CHG_W-1:0]    chg_cnt_q,   chg_cnt_d;
    logic [7:0]          lfsr_q,      lfsr_d;

    logic                lfsr_fb_c;
    logic [1:0]          rand_sel_c;

    // Taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Fold the forbidden value 3 back onto 0/1 using the next LFSR bit.
    assign rand_sel_c = (lfsr_q[1:0] != 2'd3) ? lfsr_q[1:0] : {1'b0, lfsr_q[2]};

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        change_d    = 1'b0;
        done_d      = 1'b0;
        rand_d      = rand_q;
        time_left_d = time_left_q;
        sec_cnt_d   = sec_cnt_q;
        chg_cnt_d   = chg_cnt_q;
        lfsr_d      = (lfsr_q == 8'd0) ? LFSR_SEED : {lfsr_q[6:0], lfsr_fb_c};

        case (state_q)
            IDLE, DONE: begin
                start_d     = 1'b0;
                time_left_d = '0;
                if (bus.go) begin
                    state_d     = RUN;
                    start_d     = 1'b1;
                    change_d    = 1'b1;
                    rand_d      = rand_sel_c;
                    time_left_d = TIME_W'(ROUND_SECS);
                    sec_cnt_d   = '0;
                    chg_cnt_d   = '0;
                end
            end

            RUN: begin
                if (chg_cnt_q == CHG_W'(CHANGE_CYCLES - 1)) begin
                    chg_cnt_d = '0;
                    change_d  = 1'b1;
                    rand_d    = rand_sel_c;
                end else begin
                    chg_cnt_d = chg_cnt_q + CHG_W'(1);
                end

                // Second boundary; the last one ends the round and masks any change pulse.
                if (sec_cnt_q == SEC_W'(CYCLES_PER_SEC - 1)) begin
                    sec_cnt_d = '0;
                    if (time_left_q == TIME_W'(1)) begin
                        state_d     = DONE;
                        time_left_d = '0;
                        start_d     = 1'b0;
                        done_d      = 1'b1;
                        change_d    = 1'b0;
                    end else begin
                        time_left_d = time_left_q - TIME_W'(1);
                    end
                end else begin
                    sec_cnt_d = sec_cnt_q + SEC_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            change_q    <= 1'b0;
            done_q      <= 1'b0;
            rand_q      <= 2'd0;
            time_left_q <= '0;
            sec_cnt_q   <= '0;
            chg_cnt_q   <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            change_q    <= change_d;
            done_q      <= done_d;
            rand_q      <= rand_d;
            time_left_q <= time_left_d;
            sec_cnt_q   <= sec_cnt_d;
            chg_cnt_q   <= chg_cnt_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign bus.start    = start_q;
    assign bus.change   = change_q;
    assign bus.done     = done_q;
    assign bus.randNum  = rand_q;
    assign bus.timeLeft = time_left_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a short round (10 cycles/s, 3 s, change every 4).
module tb_round_ctrl;

    localparam int unsigned CPS = 10;
    localparam int unsigned RS  = 3;
    localparam int unsigned CC  = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    round_ctrl_if bus ();

    round_ctrl #(
        .CYCLES_PER_SEC(CPS),
        .ROUND_SECS    (RS),
        .CHANGE_CYCLES (CC),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        if (s == 8'd0) return 8'hA5;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [1:0] rand_map(input logic [7:0] s);
        if (s[1:0] != 2'd3) return s[1:0];
        return {1'b0, s[2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.go = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL reset_start: got %0b want 0", bus.start); end
        total++; if (bus.change !== 1'b0) begin bad++; $display("FAIL reset_change: got %0b want 0", bus.change); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        total++; if (bus.randNum !== 2'd0) begin bad++; $display("FAIL reset_rand: got %0d want 0", bus.randNum); end
        total++; if (bus.timeLeft !== 6'd0) begin bad++; $display("FAIL reset_time: got %0d want 0", bus.timeLeft); end
        total++; if (2'(dut.state_q) !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", 2'(dut.state_q)); end
        rst = 1'b1;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        // First edge after reset samples the seed: A5 -> low bits 01.
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL go_start: got %0b want 1", bus.start); end
        total++; if (bus.change !== 1'b1) begin bad++; $display("FAIL go_change: got %0b want 1", bus.change); end
        total++; if (bus.timeLeft !== 6'd3) begin bad++; $display("FAIL go_time: got %0d want 3", bus.timeLeft); end
        total++; if (bus.randNum !== 2'd1) begin bad++; $display("FAIL go_rand: got %0d want 1", bus.randNum); end
    endtask

    // Starts at RUN cycle 0; optionally pulses go at RUN cycle 12; ends at cycle 30 checked.
    task automatic run_round(input string tag, input bit go_mid);
        int n_change;
        int n_start;
        n_change = 0;
        n_start  = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.change === 1'b1) n_change++;
            if (bus.start === 1'b1) n_start++;
            total++;
            if (bus.change !== ((k % 4) == 0)) begin
                bad++; $display("FAIL %s_change_c%0d: got %0b want %0b", tag, k, bus.change, (k % 4) == 0);
            end
            total++;
            if (bus.timeLeft !== 6'(3 - k / 10)) begin
                bad++; $display("FAIL %s_time_c%0d: got %0d want %0d", tag, k, bus.timeLeft, 3 - k / 10);
            end
            bus.go = (go_mid && k == 12);
            tick();
            bus.go = 1'b0;
        end
        total++; if (n_change != 8) begin bad++; $display("FAIL %s_nchange: got %0d want 8", tag, n_change); end
        total++; if (n_start != 30) begin bad++; $display("FAIL %s_nstart: got %0d want 30", tag, n_start); end
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL %s_end_start: got %0b want 0", tag, bus.start); end
        total++; if (bus.timeLeft !== 6'd0) begin bad++; $display("FAIL %s_end_time: got %0d want 0", tag, bus.timeLeft); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL %s_end_done: got %0b want 1", tag, bus.done); end
        total++; if (bus.change !== 1'b0) begin bad++; $display("FAIL %s_end_change: got %0b want 0", tag, bus.change); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %0b want 0", tag, bus.done); end
        total++; if (bus.change !== 1'b0) begin bad++; $display("FAIL %s_post_change: got %0b want 0", tag, bus.change); end
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL %s_post_start: got %0b want 0", tag, bus.start); end
    endtask

    task automatic test_round();
        run_round("round", 1'b0);
    endtask

    task automatic test_go_ignored();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        run_round("goign", 1'b1);
        tick();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL restart_start: got %0b want 1", bus.start); end
        total++; if (bus.timeLeft !== 6'd3) begin bad++; $display("FAIL restart_time: got %0d want 3", bus.timeLeft); end
        total++; if (bus.change !== 1'b1) begin bad++; $display("FAIL restart_change: got %0b want 1", bus.change); end
    endtask

    task automatic test_reset_midround();
        logic [7:0] s;
        logic [1:0] exp_rand;
        for (int k = 0; k < 15; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL midrst_start: got %0b want 0", bus.start); end
        total++; if (bus.timeLeft !== 6'd0) begin bad++; $display("FAIL midrst_time: got %0d want 0", bus.timeLeft); end
        total++; if (bus.change !== 1'b0) begin bad++; $display("FAIL midrst_change: got %0b want 0", bus.change); end
        total++; if (dut.lfsr_q !== 8'hA5) begin bad++; $display("FAIL midrst_lfsr: got %h want a5", dut.lfsr_q); end
        // Seven idle shifts, then go samples the 7th successor of the seed.
        s = 8'hA5;
        for (int k = 0; k < 7; k++) begin
            tick();
            s = lfsr_step(s);
        end
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        exp_rand = 2'd0;
        for (int k = 0; k < 30; k++) begin
            if ((k % 4) == 0) exp_rand = rand_map(s);
            total++;
            if (bus.randNum !== exp_rand) begin
                bad++; $display("FAIL golden_rand_c%0d: got %0d want %0d", k, bus.randNum, exp_rand);
            end
            s = lfsr_step(s);
            tick();
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL golden_done: got %0b want 1", bus.done); end
    endtask

    task automatic test_many_rounds();
        bit seen [3];
        bit found;
        seen = '{1'b0, 1'b0, 1'b0};
        for (int r = 0; r < 2000; r++) begin
            bus.go = 1'b1;
            tick();
            bus.go = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                if (bus.done === 1'b1) begin
                    found = 1'b1;
                end else begin
                    if (bus.change === 1'b1) begin
                        total++;
                        if (bus.randNum === 2'd3 || $isunknown(bus.randNum)) begin
                            bad++; $display("FAIL many_rand_r%0d: got %0d want 0..2", r, bus.randNum);
                        end else begin
                            seen[bus.randNum] = 1'b1;
                        end
                    end
                    tick();
                end
            end
            total++;
            if (!found) begin bad++; $display("FAIL many_timeout_r%0d: got no done want done within 40", r); end
        end
        total++;
        if (!(seen[0] && seen[1] && seen[2])) begin
            bad++; $display("FAIL many_coverage: got seen=%0b%0b%0b want 111", seen[2], seen[1], seen[0]);
        end
    endtask

    task automatic test_lfsr_period();
        logic [7:0] s;
        int first_ret;
        int model_err;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        s = 8'hA5;
        first_ret = 0;
        model_err = 0;
        for (int n = 1; n <= 255; n++) begin
            tick();
            s = lfsr_step(s);
            if (dut.lfsr_q !== s) model_err++;
            if (first_ret == 0 && dut.lfsr_q === 8'hA5) first_ret = n;
        end
        total++; if (first_ret != 255) begin bad++; $display("FAIL lfsr_period: got %0d want 255", first_ret); end
        total++; if (model_err != 0) begin bad++; $display("FAIL lfsr_model: got %0d diffs want 0", model_err); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.go = 1'b0;
        test_reset();
        test_round();
        test_go_ignored();
        test_reset_midround();
        test_many_rounds();
        test_lfsr_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
